pipeline_stage_reg: RTL and testbench
=====================================

// Module: pipeline_stage_reg
// PURPOSE
//  Generic, parametrised inter-stage pipeline register for the CPU pipeline (fetch/decode,
//  decode/execute, execute/mem, mem/writeback latches). It carries an opaque DATA_W payload.
//  It replaces the enable/nop state input with a valid/ready handshake, an explicit hold and flush.
//  An optional skid entry breaks the combinational ready path.
//  A saturating stall-cycle counter supports hazard-unit tuning.
// PARAMETERS
//  DATA_W     64          payload width in bits (packed control + data fields of the stage)
//  NOP_VALUE  '0          payload driven on out_data when the stage is empty / after flush / at reset
//  SKID_EN    1           1: 2-entry skid buffer, in_ready registered; 0: single entry, in_ready combinational
//  CNT_W      16          width of stall_cnt
// PORTS
//  CLK        in   1       clock, rising edge
//  RST        in   1       asynchronous reset, active-high
//  in_valid   in   1       upstream stage presents a valid payload
//  in_ready   out  1       stage can accept; transfer when in_valid & in_ready
//  in_data    in   DATA_W  upstream payload
//  out_valid  out  1       out_data holds a valid instruction
//  out_ready  in   1       downstream accepts; transfer when out_valid & out_ready & !hold
//  out_data   out  DATA_W  payload to next stage (NOP_VALUE when !out_valid)
//  hold       in   1       hazard unit freeze: no transfer out this cycle (acts as out_ready=0)
//  flush      in   1       squash all held entries (branch/jump mispredict)
//  clr_cnt    in   1       synchronous clear of stall_cnt
//  stall_cnt  out  CNT_W   cycles with out_valid & !(out_ready & !hold), saturating
// BEHAVIOUR
//  Reset (RST=1, async): state EMPTY, out_valid=0, out_data=NOP_VALUE, skid entry=NOP_VALUE,
//   stall_cnt=0, in_ready=0 while RST high. Reset mid-transfer drops both entries, no partial state.
//  Define pop = out_valid & out_ready & !hold; push = in_valid & in_ready.
//  SKID_EN=1 FSM (main reg M, skid reg S):
//   EMPTY: push -> M<=in_data, FULL.
//   FULL : push&!pop -> S<=in_data, SKID; push&pop -> M<=in_data, FULL; !push&pop -> EMPTY.
//   SKID : pop -> M<=S, S<=NOP_VALUE, FULL; else hold both (no push possible).
//   in_ready = (state != SKID) & !RST, a function of registered state only.
//   No combinational path out_ready/hold -> in_ready.
//  SKID_EN=0: single entry M; in_ready = (!out_valid | pop) & !RST (combinational).
//   push&pop same cycle -> M<=in_data, out_valid stays 1.
//  Latency: 1 cycle from push to out_valid when stage empty; throughput 1/cycle with out_ready=1.
//  out_valid = (state != EMPTY); out_data = M when valid, else NOP_VALUE.
//  Data order strictly FIFO; no payload dropped or duplicated except by flush.
//  flush: highest priority, next edge -> EMPTY, M and S <= NOP_VALUE.
//   A push coincident with flush is discarded. A pop coincident with flush still counts as
//   consumed downstream.
//  hold & flush together: flush wins.
//  hold with out_valid=0: no effect on state; pushes still accepted while in_ready=1.
//  stall_cnt: +1 per cycle with out_valid & !pop; saturates at 2^CNT_W-1 (no wrap).
//   clr_cnt has priority over increment. stall_cnt is unaffected by flush.
// TESTING
//  1 Stream 8 payloads 0x01..0x08 with out_ready=1, SKID_EN=1 -> out seq 0x01..0x08,
//    one per cycle, first 1 cycle after push.
//  2 Stream 0xA,0xB with out_ready=0 -> state SKID, in_ready=0 next cycle;
//    raise out_ready -> 0xA then 0xB, no loss; stall_cnt counts the stalled cycles.
//  3 FULL with 0x55, assert flush+in_valid(0x66) same cycle -> next cycle out_valid=0,
//    out_data=NOP_VALUE, 0x66 never emitted.
//  4 hold=1 for 3 cycles with out_ready=1, payload 0x77 -> 0x77 held, stall_cnt +3, then
//    released on hold=0.
//  5 CNT_W=4, stall 20 cycles -> stall_cnt=15 (saturated); clr_cnt with stall -> 0.
//  6 Assert RST mid-SKID and mid-stream, both SKID_EN=0 and 1 -> immediately out_valid=0,
//    out_data=NOP_VALUE, stall_cnt=0, in_ready=0 until RST low.

Source files
------------

// File: rtl/pipeline_stage_reg.sv
// Inter-stage pipeline register with a valid/ready handshake, hold, flush and an optional skid entry.
// Also counts stalled cycles with a saturating counter for hazard-unit tuning.
module pipeline_stage_reg #(
    parameter int                DATA_W    = 64,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int                SKID_EN   = 1,
    parameter int                CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              hold,
    input  logic              flush,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              push;
    logic              pop;

    assign out_valid = (state != EMPTY);
    assign out_data  = out_valid ? main_q : NOP_VALUE;
    assign pop       = out_valid & out_ready & ~hold;
    assign push      = in_valid & in_ready;

    // With the skid entry, in_ready depends on registered state only, which keeps
    // out_ready/hold off the upstream timing path.
    always_comb begin
        in_ready = 1'b0;
        if (SKID_EN != 0)
            in_ready = (state != SKID) & ~rst;
        else
            in_ready = (~out_valid | pop) & ~rst;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; flush is checked before the handshake so it always wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= NOP_VALUE;
            skid_q <= NOP_VALUE;
        end else if (flush) begin
            state  <= EMPTY;
            main_q <= NOP_VALUE;
            skid_q <= NOP_VALUE;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_q <= in_data;
                        state  <= FULL;
                    end
                end
                FULL: begin
                    if (push && pop) begin
                        main_q <= in_data;
                    end else if (push) begin
                        // Only reachable with the skid entry: single-entry mode needs a pop to push.
                        skid_q <= in_data;
                        state  <= SKID;
                    end else if (pop) begin
                        main_q <= NOP_VALUE;
                        state  <= EMPTY;
                    end
                end
                SKID: begin
                    if (pop) begin
                        main_q <= skid_q;
                        skid_q <= NOP_VALUE;
                        state  <= FULL;
                    end
                end
                default: begin
                    state  <= EMPTY;
                    main_q <= NOP_VALUE;
                    skid_q <= NOP_VALUE;
                end
            endcase
        end
    end

    // Stall counter ignores flush; clear beats increment, and it sticks at the maximum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if (clr_cnt)
            stall_cnt <= '0;
        else if (out_valid && !pop && (stall_cnt != CNT_MAX))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Directed bench for pipeline_stage_reg: a skid instance (NOP=0xEE, 4-bit counter) driven from a
// vector table, plus a single-entry instance exercised by hand-written sequences.
module tb_pipeline_stage_reg;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       hld;
        logic       fl;
        logic       clr;
        logic       ev;
        logic [7:0] ed;
        logic       eir;
        logic [3:0] ecnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       out_ready = 1'b0;
    logic       hold = 1'b0;
    logic       flush = 1'b0;
    logic       clr_cnt = 1'b0;

    logic        ir1, ov1, ir0, ov0;
    logic [7:0]  od1, od0;
    logic [3:0]  cnt1;
    logic [15:0] cnt0;

    int checks = 0;
    int failures = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    pipeline_stage_reg #(.DATA_W(8), .NOP_VALUE(8'hEE), .SKID_EN(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .hold(hold),
        .flush(flush), .clr_cnt(clr_cnt), .stall_cnt(cnt1)
    );

    pipeline_stage_reg #(.DATA_W(8), .SKID_EN(0), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
        .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .hold(hold),
        .flush(flush), .clr_cnt(clr_cnt), .stall_cnt(cnt0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic iv, input logic [7:0] id, input logic ordy,
                          input logic hld, input logic fl, input logic clr);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        hold      = hld;
        flush     = fl;
        clr_cnt   = clr;
    endtask

    task automatic add(input logic iv, input logic [7:0] id, input logic ordy, input logic hld,
                       input logic fl, input logic clr, input logic ev, input logic [7:0] ed,
                       input logic eir, input logic [3:0] ecnt);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.hld = hld; v.fl = fl; v.clr = clr;
        v.ev = ev; v.ed = ed; v.eir = eir; v.ecnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Vector table for the skid instance: inputs for one cycle, expected outputs after the edge.
        add(0, 8'h00, 0, 0, 0, 1,  0, 8'hEE, 1, 0);
        for (int i = 1; i <= 8; i++)
            add(1, 8'(i), 1, 0, 0, 0,  1, 8'(i), 1, 0);
        add(0, 8'h00, 1, 0, 0, 0,  0, 8'hEE, 1, 0);
        // Back-pressure into the skid entry, then drain in order.
        add(1, 8'h0A, 0, 0, 0, 0,  1, 8'h0A, 1, 0);
        add(1, 8'h0B, 0, 0, 0, 0,  1, 8'h0A, 0, 1);
        add(1, 8'h0C, 0, 0, 0, 0,  1, 8'h0A, 0, 2);
        add(0, 8'h00, 1, 0, 0, 0,  1, 8'h0B, 1, 2);
        add(0, 8'h00, 1, 0, 0, 0,  0, 8'hEE, 1, 2);
        add(0, 8'h00, 0, 0, 0, 1,  0, 8'hEE, 1, 0);
        // Flush squashes a coincident push; the stalled flush cycle still counts.
        add(1, 8'h55, 0, 0, 0, 0,  1, 8'h55, 1, 0);
        add(1, 8'h66, 0, 0, 1, 0,  0, 8'hEE, 1, 1);
        add(0, 8'h00, 1, 0, 0, 0,  0, 8'hEE, 1, 1);
        add(0, 8'h00, 0, 0, 0, 1,  0, 8'hEE, 1, 0);
        // Hold freezes the output for three cycles.
        add(1, 8'h77, 1, 0, 0, 0,  1, 8'h77, 1, 0);
        add(0, 8'h00, 1, 1, 0, 0,  1, 8'h77, 1, 1);
        add(0, 8'h00, 1, 1, 0, 0,  1, 8'h77, 1, 2);
        add(0, 8'h00, 1, 1, 0, 0,  1, 8'h77, 1, 3);
        add(0, 8'h00, 1, 0, 0, 0,  0, 8'hEE, 1, 3);
        // Hold while empty still accepts a push; hold while full fills the skid entry.
        add(1, 8'h12, 1, 1, 0, 0,  1, 8'h12, 1, 3);
        add(1, 8'h13, 1, 1, 0, 0,  1, 8'h12, 0, 4);
        add(0, 8'h00, 1, 0, 0, 0,  1, 8'h13, 1, 4);
        add(0, 8'h00, 1, 0, 0, 0,  0, 8'hEE, 1, 4);
        // Hold with flush: flush wins. Flush with a pop: the pop is not a stall.
        add(1, 8'h21, 0, 0, 0, 0,  1, 8'h21, 1, 4);
        add(0, 8'h00, 0, 1, 1, 0,  0, 8'hEE, 1, 5);
        add(1, 8'h22, 1, 0, 0, 0,  1, 8'h22, 1, 5);
        add(0, 8'h00, 1, 0, 1, 0,  0, 8'hEE, 1, 5);

        // Reset state, sampled while reset is high.
        #1;
        check("rst_ov1", ov1, 0);   check("rst_od1", od1, 8'hEE);
        check("rst_ir1", ir1, 0);   check("rst_cnt1", cnt1, 0);
        check("rst_ov0", ov0, 0);   check("rst_od0", od0, 8'h00);
        check("rst_ir0", ir0, 0);   check("rst_cnt0", cnt0, 0);
        step();
        check("rst_ir1_edge", ir1, 0);
        rst = 1'b0;
        #1;
        check("rel_ir1", ir1, 1);
        check("rel_ir0", ir0, 1);
        @(negedge clk);

        foreach (vecs[i]) begin
            set_in(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].hld, vecs[i].fl, vecs[i].clr);
            step();
            check($sformatf("v%0d_out_valid", i), ov1, vecs[i].ev);
            check($sformatf("v%0d_out_data", i), od1, vecs[i].ed);
            check($sformatf("v%0d_in_ready", i), ir1, vecs[i].eir);
            check($sformatf("v%0d_stall_cnt", i), cnt1, vecs[i].ecnt);
        end

        // Saturation of the 4-bit stall counter, then clear under an ongoing stall.
        set_in(1, 8'h30, 0, 0, 0, 1);
        step();
        check("sat_start", cnt1, 0);
        for (int k = 1; k <= 20; k++) begin
            set_in(0, 8'h00, 0, 0, 0, 0);
            step();
            if (k == 14 || k == 15 || k == 20)
                check($sformatf("sat_k%0d", k), cnt1, (k > 15) ? 15 : k);
        end
        check("sat_data", od1, 8'h30);
        set_in(0, 8'h00, 0, 0, 0, 1);
        step();
        check("clr_during_stall", cnt1, 0);
        set_in(0, 8'h00, 0, 0, 0, 0);
        step();
        check("count_after_clr", cnt1, 1);
        set_in(0, 8'h00, 1, 0, 0, 0);
        step();
        check("sat_drain_ov", ov1, 0);

        // Resynchronise both instances, then exercise the single-entry instance.
        #2 rst = 1'b1;
        #1 check("rst2_ov0", ov0, 0);
        @(negedge clk);
        rst = 1'b0;
        set_in(1, 8'h81, 0, 0, 0, 0);
        #1 check("se_ir_empty", ir0, 1);
        step();
        check("se_ov", ov0, 1);
        check("se_od", od0, 8'h81);
        check("se_ir_stalled", ir0, 0);
        out_ready = 1'b1;
        #1 check("se_ir_comb_ready", ir0, 1);
        hold = 1'b1;
        #1 check("se_ir_comb_hold", ir0, 0);
        set_in(1, 8'h82, 1, 0, 0, 0);
        step();
        check("se_pushpop_ov", ov0, 1);
        check("se_pushpop_od", od0, 8'h82);
        check("se_pushpop_cnt", cnt0, 0);
        set_in(0, 8'h00, 1, 0, 0, 0);
        step();
        check("se_drain_ov", ov0, 0);
        check("se_drain_od", od0, 8'h00);

        // Reset with the skid instance in SKID and the single-entry instance stalled.
        set_in(1, 8'h90, 0, 0, 0, 0);
        step();
        set_in(1, 8'h91, 0, 0, 0, 0);
        step();
        check("pre_rst_ir1", ir1, 0);
        check("pre_rst_od1", od1, 8'h90);
        check("pre_rst_cnt1", cnt1, 1);
        check("pre_rst_od0", od0, 8'h90);
        check("pre_rst_cnt0", cnt0, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ov1", ov1, 0);  check("mid_rst_od1", od1, 8'hEE);
        check("mid_rst_ir1", ir1, 0);  check("mid_rst_cnt1", cnt1, 0);
        check("mid_rst_ov0", ov0, 0);  check("mid_rst_od0", od0, 8'h00);
        check("mid_rst_ir0", ir0, 0);  check("mid_rst_cnt0", cnt0, 0);
        set_in(1, 8'h92, 1, 0, 0, 0);
        step();
        check("rst_held_ir1", ir1, 0);
        check("rst_held_ov1", ov1, 0);
        check("rst_held_ir0", ir0, 0);
        rst = 1'b0;
        set_in(0, 8'h00, 0, 0, 0, 0);
        #1;
        check("post_rst_ir1", ir1, 1);
        check("post_rst_ov1", ov1, 0);
        check("post_rst_ir0", ir0, 1);
        step();
        check("post_rst_idle_ov1", ov1, 0);
        check("post_rst_idle_ov0", ov0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
